// File: rtl/reg_file_wb_arbiter.sv
// Writeback arbiter for the register-file write port with a pending-write scoreboard.
// Define REG_WB_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module reg_file_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sync_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          issue_stall,
  input  logic [ADDR_WIDTH-1:0]         rs1_addr,
  input  logic [ADDR_WIDTH-1:0]         rs2_addr,
  output logic                          rs1_hazard,
  output logic                          rs2_hazard,
  output logic                          wr_en_out,
  output logic [ADDR_WIDTH-1:0]         wr_addr_out,
  output logic [DATA_WIDTH-1:0]         wr_data_out
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    grant;
  logic [IdxW-1:0]       grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  commit;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NumRegs-1:0]    pending_q, pending_d;

  // Arbitration

`ifdef REG_WB_RR_ARB_EN
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] rr_cand;

  // Search starts one past the last granted index and wraps at NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    rr_cand   = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_cand = (rr_cand == IdxW'(NUM_REQ - 1)) ? IdxW'(0) : rr_cand + IdxW'(1);
      if (!grant_any && req_valid[rr_cand]) begin
        grant_any        = 1'b1;
        grant_idx        = rr_cand;
        grant[rr_cand]   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (sync_reset) begin
      rr_ptr_d = IdxW'(NUM_REQ - 1);
    end else if (grant_any) begin
      rr_ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IdxW'(NUM_REQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(i);
        grant[i]  = 1'b1;
      end
    end
  end
`endif

  assign req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Writes to register 0 are consumed without reaching the register file.
  assign commit = grant_any && (sel_addr != '0);

  // Write stage

  always_comb begin
    wr_en_d   = commit;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (commit) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
    if (sync_reset) begin
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;

  // Pending-write scoreboard

  assign issue_stall = pending_q[issue_rd];
  assign rs1_hazard  = pending_q[rs1_addr];
  assign rs2_hazard  = pending_q[rs2_addr];

  // Clear before set so a same-cycle issue to the committing register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[wr_addr_q] = 1'b0;
    end
    if (issue_valid && !issue_stall && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
    if (sync_reset) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifndef SYNTHESIS
  // Requester protocol and internal invariants
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_grant_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (req_ready & ~req_valid) == '0);

  a_reg0_never_pending: assert property (@(posedge clk) disable iff (reset)
    !pending_q[0]);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
    a_hold_until_grant: assert property (@(posedge clk) disable iff (reset || sync_reset)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] &&
         $stable(req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(req_data[g*DATA_WIDTH +: DATA_WIDTH])));
  end
`endif

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Randomized scoreboard bench for reg_file_wb_arbiter: an abstract model predicts grants,
// hazards and register-file writes; a monitor pops expected writes as the DUT presents them.
module tb_reg_file_wb_arbiter;

  localparam int NR   = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sync_reset;
  logic [NR-1:0]        req_valid;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_stall;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic                 rs1_hazard;
  logic                 rs2_hazard;
  logic                 wr_en_out;
  logic [AW-1:0]        wr_addr_out;
  logic [DW-1:0]        wr_data_out;

  reg_file_wb_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (sync_reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_stall(issue_stall),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_hazard (rs1_hazard),
    .rs2_hazard (rs2_hazard),
    .wr_en_out  (wr_en_out),
    .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int            tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Requester state: each source holds one request until it is granted.
  logic          rv  [NR];
  logic [AW-1:0] ra  [NR];
  logic [DW-1:0] rdat[NR];

  // Reference model state
  logic          m_pend[NREG];
  int            rr_last;
  logic          m_wen;
  logic [AW-1:0] m_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    rr_last = NR - 1;
    m_wen   = 1'b0;
    m_waddr = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = rv[i];
      req_addr[i*AW +: AW]    = ra[i];
      req_data[i*DW +: DW]    = rdat[i];
    end
  endtask

  task automatic clear_issue();
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    sync_reset  = 1'b0;
  endtask

  task automatic post(input int src, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    rv[src]   = 1'b1;
    ra[src]   = addr;
    rdat[src] = data;
  endtask

  // Called at a negedge with inputs already chosen; returns at the next negedge.
  task automatic step();
    int   g;
    logic stall;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
`ifdef REG_WB_RR_ARB_EN
      i = (rr_last + 1 + k) % NR;
`else
      i = k;
`endif
      if (g < 0 && rv[i]) g = i;
    end
    check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    stall = m_pend[issue_rd];
    check("issue_stall", 32'(issue_stall), 32'(stall));
    check("rs1_hazard", 32'(rs1_hazard), 32'(m_pend[rs1_addr]));
    check("rs2_hazard", 32'(rs2_hazard), 32'(m_pend[rs2_addr]));

    if (sync_reset) begin
      model_reset();
    end else begin
      if (m_wen) m_pend[m_waddr] = 1'b0;
      if (issue_valid && !stall && issue_rd != '0) m_pend[issue_rd] = 1'b1;
      m_wen = 1'b0;
      if (g >= 0) begin
        rr_last = g;
        if (ra[g] != '0) begin
          exp_q.push_back('{edge_cnt + 1, ra[g], rdat[g]});
          m_wen   = 1'b1;
          m_waddr = ra[g];
        end
        rv[g] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  initial begin : monitor
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
        e = exp_q.pop_front();
        check("wr_en_out", 32'(wr_en_out), 32'd1);
        check("wr_addr_out", 32'(wr_addr_out), 32'(e.addr));
        check("wr_data_out", wr_data_out, e.data);
      end else begin
        check("wr_en_idle", 32'(wr_en_out), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rv[i]   = 1'b0;
      ra[i]   = '0;
      rdat[i] = '0;
    end
    clear_issue();
    drive();
    model_reset();

    // Reset held, then released with no traffic
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
      check("rst_wr_data", wr_data_out, 32'd0);
      step();
    end

    // Single write, addr 5
    post(0, 5'd5, 32'hDEADBEEF);
    repeat (3) step();

    // All three sources at once
    post(0, 5'd1, 32'h11111111);
    post(1, 5'd2, 32'h22222222);
    post(2, 5'd3, 32'h33333333);
    repeat (5) step();

    // RAW/WAW on register 7, cleared by writeback
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    rs1_addr = 5'd7;
    step();
    issue_valid = 1'b0;
    post(0, 5'd7, 32'hCAFE0007);
    repeat (3) step();
    clear_issue();

    // Issue to register 9 in the cycle its write commits
    post(0, 5'd9, 32'h00000009);
    step();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; rs2_addr = 5'd9;
    step();
    clear_issue();
    post(0, 5'd9, 32'h00000099);
    repeat (3) step();

    // Register 0 write and issue
    post(0, 5'd0, 32'h00001234);
    step();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    clear_issue();
    step();

    // sync_reset while a write is on the output
    post(0, 5'd3, 32'h0BADF00D);
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_valid = 1'b0; sync_reset = 1'b1;
    step();
    sync_reset = 1'b0; rs1_addr = 5'd3;
    repeat (2) step();
    clear_issue();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 99) < 45)
          post(i, AW'($urandom_range(0, 11)), $urandom());
      end
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = AW'($urandom_range(0, 11));
      rs1_addr    = AW'($urandom_range(0, 11));
      rs2_addr    = AW'($urandom_range(0, 11));
      sync_reset  = ($urandom_range(0, 199) == 0);
      step();

      if (n == 1500) begin
        // Asynchronous reset mid-traffic; outstanding requests are re-presented after.
        clear_issue();
        rs1_addr = AW'($urandom_range(1, 11));
        reset    = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("arst_wr_en", 32'(wr_en_out), 32'd0);
        check("arst_rs1", 32'(rs1_hazard), 32'd0);
        check("arst_addr", 32'(wr_addr_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    end

    // Drain
    clear_issue();
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
    repeat (4) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
